// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, credit width, price table and timeout default
package vend_pkg;

    localparam int PRICE_W        = 4;
    localparam int TIMEOUT_CYCLES = 500_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    // Product price in units of 100
    function automatic int unsigned item_price(input logic [1:0] item);
        case (item)
            2'd0:    return 1;
            2'd1:    return 3;
            2'd2:    return 5;
            default: return 7;
        endcase
    endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// rtl/coin_edge_detect.sv - two-flop synchronizer with one-cycle rising-edge pulse
module coin_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_coin,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Bring the asynchronous button level into the clock domain and keep last value
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_coin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - vending FSM top; optional idle refund enabled by VEND_TIMEOUT_EN
module vending_controller #(
    parameter int PRICE_W        = vend_pkg::PRICE_W,
    parameter int TIMEOUT_CYCLES = vend_pkg::TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_100,
    input  logic               coin_500,
    input  logic               sel_valid,
    input  logic [1:0]         sel_item,
    input  logic               cancel,
    output logic [PRICE_W-1:0] credit,
    output logic               dispense,
    output logic [1:0]         dispense_item,
    output logic               change_valid,
    output logic [PRICE_W-1:0] change_units,
    output logic               coin_reject,
    output logic               busy
);
    import vend_pkg::*;

    localparam int               CW         = PRICE_W + 1;
    localparam logic [PRICE_W:0] MAX_CREDIT = {1'b0, {PRICE_W{1'b1}}};
    localparam logic [PRICE_W-1:0] UNITS_100 = PRICE_W'(1);
    localparam logic [PRICE_W-1:0] UNITS_500 = PRICE_W'(5);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRICE_W-1:0] r_credit;
    logic [PRICE_W-1:0] w_credit_nxt;
    logic [1:0]         r_item;

    logic               w_rise_100;
    logic               w_rise_500;
    logic               w_coin_open;
    logic               w_take_100;
    logic               w_take_500;
    logic [PRICE_W-1:0] w_add;
    logic [PRICE_W:0]   w_price;
    logic               w_timeout;

    coin_edge_detect u_edge_100 (
        .i_clk   (clk),
        .i_reset (reset),
        .i_coin  (coin_100),
        .o_rise  (w_rise_100)
    );

    coin_edge_detect u_edge_500 (
        .i_clk   (clk),
        .i_reset (reset),
        .i_coin  (coin_500),
        .o_rise  (w_rise_500)
    );

    // Coins are only taken while collecting; a 500 edge always shadows a same-cycle 100 edge
    assign w_coin_open = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_take_500  = w_coin_open && w_rise_500 &&
                         (({1'b0, r_credit} + {1'b0, UNITS_500}) <= MAX_CREDIT);
    assign w_take_100  = w_coin_open && w_rise_100 && !w_rise_500 &&
                         (({1'b0, r_credit} + {1'b0, UNITS_100}) <= MAX_CREDIT);
    assign w_add       = w_take_500 ? UNITS_500 : (w_take_100 ? UNITS_100 : '0);
    assign w_price     = CW'(item_price(r_item));

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] r_idle_cnt;
    logic            w_activity;

    assign w_activity = w_rise_100 | w_rise_500 | sel_valid;
    assign w_timeout  = (r_state == ST_COLLECT) && !w_activity &&
                        (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive quiet COLLECT cycles; any coin edge or selection restarts it
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_COLLECT) || w_activity || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and credit update for the vend sequence
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        case (r_state)
            ST_IDLE: begin
                w_credit_nxt = r_credit + w_add;
                if (w_take_500 || w_take_100) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                w_credit_nxt = r_credit + w_add;
                if (cancel) begin
                    w_state_nxt = ST_CHANGE;
                end else if (sel_valid) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = ST_CHANGE;
                end
            end
            ST_CHECK: begin
                if ({1'b0, r_credit} >= w_price) begin
                    w_state_nxt = ST_DISPENSE;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_DISPENSE: begin
                w_credit_nxt = r_credit - w_price[PRICE_W-1:0];
                w_state_nxt  = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                w_credit_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_credit_nxt = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State, credit and latched selection registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_item   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            if ((r_state == ST_COLLECT) && sel_valid && !cancel) begin
                r_item <= sel_item;
            end
        end
    end

    assign credit        = r_credit;
    assign dispense      = (r_state == ST_DISPENSE);
    assign dispense_item = dispense ? r_item : 2'b00;
    assign change_valid  = (r_state == ST_CHANGE);
    assign change_units  = change_valid ? r_credit : '0;
    assign coin_reject   = (w_rise_500 && !w_take_500) || (w_rise_100 && !w_take_100);
    assign busy          = (r_state == ST_CHECK) || (r_state == ST_DISPENSE) ||
                           (r_state == ST_CHANGE);

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - randomized self-checking bench against a credit-level model
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_100;
    logic       coin_500;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic [3:0] credit;
    logic       dispense;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [3:0] change_units;
    logic       coin_reject;
    logic       busy;

    int total = 0;
    int bad = 0;
    int m_credit = 0;

    always #5 clk = ~clk;

    vending_controller #(
        .PRICE_W        (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_100      (coin_100),
        .coin_500      (coin_500),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .credit        (credit),
        .dispense      (dispense),
        .dispense_item (dispense_item),
        .change_valid  (change_valid),
        .change_units  (change_units),
        .coin_reject   (coin_reject),
        .busy          (busy)
    );

    function automatic int price_of(input int item);
        case (item)
            0:       return 1;
            1:       return 3;
            2:       return 5;
            default: return 7;
        endcase
    endfunction

    task automatic do_coin(input bit c100, input bit c500);
        int exp_credit;
        bit exp_rej;
        exp_credit = m_credit;
        exp_rej    = 1'b0;
        if (c500) begin
            if (m_credit + 5 <= 15) exp_credit = m_credit + 5;
            else exp_rej = 1'b1;
        end
        if (c100) begin
            if (c500) exp_rej = 1'b1;
            else if (m_credit + 1 <= 15) exp_credit = m_credit + 1;
            else exp_rej = 1'b1;
        end
        coin_100 = c100;
        coin_500 = c500;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (coin_reject !== exp_rej) begin
            bad++;
            $display("FAIL coin_reject: got %0b expected %0b", coin_reject, exp_rej);
        end
        @(posedge clk);
        #1;
        total++;
        if (credit !== 4'(exp_credit)) begin
            bad++;
            $display("FAIL coin_credit: got %0d expected %0d", credit, exp_credit);
        end
        total++;
        if (coin_reject !== 1'b0) begin
            bad++;
            $display("FAIL coin_reject_width: got %0b expected 0", coin_reject);
        end
        coin_100 = 1'b0;
        coin_500 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_credit = exp_credit;
    endtask

    task automatic do_select(input int item);
        int p;
        int rem;
        p         = price_of(item);
        sel_item  = 2'(item);
        sel_valid = 1'b1;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        if (m_credit == 0) begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL sel_in_idle: busy got %0b expected 0", busy);
            end
            @(posedge clk);
            #1;
            total++;
            if (dispense !== 1'b0 || credit !== 4'd0) begin
                bad++;
                $display("FAIL sel_in_idle_out: dispense=%0b credit=%0d expected 0/0", dispense, credit);
            end
        end else begin
            total++;
            if (busy !== 1'b1 || dispense !== 1'b0) begin
                bad++;
                $display("FAIL check_state: busy=%0b dispense=%0b expected 1/0", busy, dispense);
            end
            @(posedge clk);
            #1;
            if (m_credit >= p) begin
                total++;
                if (dispense !== 1'b1 || dispense_item !== 2'(item)) begin
                    bad++;
                    $display("FAIL dispense: got %0b item %0d expected 1 item %0d", dispense, dispense_item, item);
                end
                rem = m_credit - p;
                @(posedge clk);
                #1;
                total++;
                if (dispense !== 1'b0) begin
                    bad++;
                    $display("FAIL dispense_width: got %0b expected 0", dispense);
                end
                if (rem > 0) begin
                    total++;
                    if (change_valid !== 1'b1 || change_units !== 4'(rem)) begin
                        bad++;
                        $display("FAIL vend_change: valid=%0b units=%0d expected 1/%0d", change_valid, change_units, rem);
                    end
                    @(posedge clk);
                    #1;
                end else begin
                    total++;
                    if (change_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL no_change: change_valid got %0b expected 0", change_valid);
                    end
                end
                total++;
                if (credit !== 4'd0 || busy !== 1'b0 || change_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL after_vend: credit=%0d busy=%0b cv=%0b expected 0/0/0", credit, busy, change_valid);
                end
                m_credit = 0;
            end else begin
                total++;
                if (dispense !== 1'b0 || dispense_item !== 2'd0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL short_credit: dispense=%0b item=%0d busy=%0b expected 0/0/0", dispense, dispense_item, busy);
                end
                total++;
                if (credit !== 4'(m_credit)) begin
                    bad++;
                    $display("FAIL short_credit_keep: got %0d expected %0d", credit, m_credit);
                end
            end
        end
    endtask

    task automatic do_cancel(input bit with_sel);
        sel_item  = 2'($urandom_range(0, 3));
        sel_valid = with_sel;
        cancel    = 1'b1;
        @(posedge clk);
        #1;
        cancel    = 1'b0;
        sel_valid = 1'b0;
        if (m_credit == 0) begin
            total++;
            if (busy !== 1'b0 || change_valid !== 1'b0) begin
                bad++;
                $display("FAIL cancel_in_idle: busy=%0b cv=%0b expected 0/0", busy, change_valid);
            end
        end else begin
            total++;
            if (change_valid !== 1'b1 || change_units !== 4'(m_credit) || busy !== 1'b1) begin
                bad++;
                $display("FAIL refund: cv=%0b units=%0d busy=%0b expected 1/%0d/1", change_valid, change_units, busy, m_credit);
            end
            @(posedge clk);
            #1;
            total++;
            if (credit !== 4'd0 || change_valid !== 1'b0 || change_units !== 4'd0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL after_refund: credit=%0d cv=%0b units=%0d busy=%0b expected all 0", credit, change_valid, change_units, busy);
            end
            m_credit = 0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (credit !== 4'd0 || dispense !== 1'b0 || change_valid !== 1'b0 || coin_reject !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: credit=%0d disp=%0b cv=%0b rej=%0b busy=%0b expected all 0", credit, dispense, change_valid, coin_reject, busy);
        end
        total++;
        if (dispense_item !== 2'd0 || change_units !== 4'd0) begin
            bad++;
            $display("FAIL reset_data: item=%0d units=%0d expected 0/0", dispense_item, change_units);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_credit = 0;
    endtask

    task automatic test_exact_vend;
        repeat (3) do_coin(1'b1, 1'b0);
        total++;
        if (credit !== 4'd3) begin
            bad++;
            $display("FAIL exact_credit: got %0d expected 3", credit);
        end
        do_select(1);
    endtask

    task automatic test_vend_with_change;
        do_coin(1'b0, 1'b1);
        do_select(0);
    endtask

    task automatic test_insufficient;
        do_coin(1'b1, 1'b0);
        do_coin(1'b1, 1'b0);
        do_select(2);
        do_cancel(1'b0);
    endtask

    task automatic test_overflow;
        repeat (3) do_coin(1'b0, 1'b1);
        do_coin(1'b1, 1'b0);
        do_coin(1'b0, 1'b1);
        do_cancel(1'b0);
        do_coin(1'b1, 1'b1);
        do_coin(1'b1, 1'b1);
        do_cancel(1'b1);
    endtask

    task automatic test_busy_reject;
        do_coin(1'b1, 1'b0);
        coin_500 = 1'b1;
        @(posedge clk);
        #1;
        sel_item  = 2'd0;
        sel_valid = 1'b1;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || coin_reject !== 1'b1) begin
            bad++;
            $display("FAIL busy_coin_reject: busy=%0b rej=%0b expected 1/1", busy, coin_reject);
        end
        @(posedge clk);
        #1;
        total++;
        if (dispense !== 1'b1 || coin_reject !== 1'b0) begin
            bad++;
            $display("FAIL busy_coin_dispense: disp=%0b rej=%0b expected 1/0", dispense, coin_reject);
        end
        @(posedge clk);
        #1;
        total++;
        if (credit !== 4'd0 || change_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_coin_credit: credit=%0d cv=%0b expected 0/0", credit, change_valid);
        end
        coin_500 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_credit = 0;
    endtask

    task automatic test_reset_mid;
        do_coin(1'b0, 1'b1);
        do_coin(1'b1, 1'b0);
        sel_item  = 2'd3;
        sel_valid = 1'b1;
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_check: busy got %0b expected 1", busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (credit !== 4'd0 || busy !== 1'b0 || dispense !== 1'b0 || change_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: credit=%0d busy=%0b disp=%0b cv=%0b expected all 0", credit, busy, dispense, change_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (dispense !== 1'b0 || change_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_after: disp=%0b cv=%0b expected 0/0", dispense, change_valid);
        end
        m_credit = 0;
    endtask

    task automatic test_random;
        int op;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1:    do_coin(1'b1, 1'b0);
                2:       do_coin(1'b0, 1'b1);
                3:       do_coin(1'b1, 1'b1);
                4, 5:    do_select($urandom_range(0, 3));
                6:       do_cancel(1'b0);
                default: do_cancel(1'b1);
            endcase
        end
        do_cancel(1'b0);
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        bit seen;
        do_coin(1'b0, 1'b1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (change_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || n != 7) begin
            bad++;
            $display("FAIL timeout_latency: seen=%0b after %0d polls expected 1 after 7", seen, n);
        end
        total++;
        if (change_units !== 4'd5) begin
            bad++;
            $display("FAIL timeout_units: got %0d expected 5", change_units);
        end
        @(posedge clk);
        #1;
        total++;
        if (credit !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: credit=%0d busy=%0b expected 0/0", credit, busy);
        end
        m_credit = 0;
    endtask
`else
    task automatic test_timeout;
        do_coin(1'b0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (credit !== 4'd5 || busy !== 1'b0 || change_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: credit=%0d busy=%0b cv=%0b expected 5/0/0", credit, busy, change_valid);
        end
        do_cancel(1'b0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        coin_100  = 1'b0;
        coin_500  = 1'b0;
        sel_valid = 1'b0;
        sel_item  = 2'd0;
        cancel    = 1'b0;
        test_reset();
        test_exact_vend();
        test_vend_with_change();
        test_insufficient();
        test_overflow();
        test_busy_reject();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Parameter PRICE_W, default 4, credit/price width in units of 100 (max credit 15 = 1500).
REQ-002 Parameter TIMEOUT_CYCLES, default 500_000_000, idle cycles before automatic refund (only with VEND_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin_100  input  1  asynchronous button level, one 100 coin per rising edge.
REQ-006 coin_500  input  1  asynchronous button level, one 500 coin per rising edge.
REQ-007 sel_valid  input  1  single-cycle product request strobe.
REQ-008 sel_item  input  2  product index, 0..3, valid with sel_valid.
REQ-009 cancel  input  1  single-cycle refund request.
REQ-010 credit  output  PRICE_W  current accumulated credit, units of 100.
REQ-011 dispense  output  1  one-cycle pulse, product released.
REQ-012 dispense_item  output  2  product index, valid with dispense.
REQ-013 change_valid  output  1  one-cycle pulse, change/refund issued.
REQ-014 change_units  output  PRICE_W  change amount, valid with change_valid.
REQ-015 coin_reject  output  1  one-cycle pulse, coin refused.
REQ-016 busy  output  1  high in CHECK, DISPENSE, CHANGE.

Function
REQ-017 Each coin input SHALL pass a 2-flop synchronizer plus rising-edge detector; credit SHALL reflect a coin on the 3rd rising clk edge after the input goes high.
REQ-018 FSM states SHALL be IDLE, COLLECT, CHECK, DISPENSE, CHANGE.
REQ-019 IDLE: first accepted coin -> COLLECT; sel_valid and cancel ignored.
REQ-020 COLLECT: coins accumulate; sel_valid -> CHECK (sel_item latched); cancel -> CHANGE with change_units = credit.
REQ-021 CHECK (1 cycle): credit >= price[item] -> DISPENSE; else -> COLLECT, credit unchanged.
REQ-022 DISPENSE (1 cycle): dispense pulse, credit -= price; remainder > 0 -> CHANGE, else -> IDLE.
REQ-023 CHANGE (1 cycle): change_valid pulse with remaining credit, credit cleared, -> IDLE.
REQ-024 A coin whose addition would exceed 15 SHALL be rejected (coin_reject, credit unchanged); no wrap-around.
REQ-025 Coin edges of both types in the same cycle: 500 accepted, 100 rejected.
REQ-026 Coin edges in CHECK, DISPENSE, CHANGE SHALL be rejected.
REQ-027 sel_valid and cancel in the same COLLECT cycle: cancel wins.
REQ-028 Output pulses SHALL be exactly one cycle wide; change_units, dispense_item are 0 when their strobe is low.

Reset
REQ-029 reset SHALL force IDLE, credit=0, all pulses low, busy low, synchronizers and timeout counter cleared, overriding every other input including mid-transaction; no change is issued for the discarded credit.

Configuration
REQ-030 Macro VEND_TIMEOUT_EN defined: in COLLECT, TIMEOUT_CYCLES consecutive cycles without coin edge or sel_valid -> CHANGE refunding full credit; counter restarts on every coin edge or sel_valid.
REQ-031 Macro VEND_TIMEOUT_EN undefined: no counter logic; COLLECT persists indefinitely.

Structure
REQ-032 Package vend_pkg SHALL hold the state enum, PRICE_W, price table (item0=1, item1=3, item2=5, item3=7 units), and default TIMEOUT_CYCLES.
REQ-033 Sub-module coin_edge_detect (synchronizer + rising-edge pulse) SHALL be instantiated once per coin input.

Verification
REQ-034 reset; coin_100 x3 -> credit=3; sel item1 -> dispense, dispense_item=1, no change_valid, credit=0, IDLE.
REQ-035 coin_500; sel item0 -> dispense item0, then change_valid with change_units=4, credit=0.
REQ-036 coin_100 x2; sel item2 -> no dispense, state back to COLLECT, credit=2; cancel -> change_units=2.
REQ-037 coin_500 x3 (credit 15); coin_100 -> coin_reject, credit stays 15; simultaneous coin_100/coin_500 from credit 0 -> credit=5, one coin_reject.
REQ-038 credit=6, assert reset during CHECK -> next cycle IDLE, credit=0, no dispense or change_valid.
REQ-039 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=10: coin_500 then idle 10 cycles -> change_valid with change_units=5, IDLE.
